ysyx_22050019_ifu: RTL and testbench

Instruction fetch unit for the npc core: owns the architectural PC, issues one instruction read at a time to the instruction memory port over a valid/ready handshake, and holds the fetched word for the decode stage until it is accepted. It sits between the PC update/redirect logic in the execute stage (upstream) and the decode stage (downstream). Redirects from execute cancel any wrong-path fetch.

---
 rtl/ysyx_22050019_pkg.sv | 15 +
 rtl/ysyx_22050019_ifu_pc.sv | 38 +++
 rtl/ysyx_22050019_ifu.sv | 118 +++++++++++
 tb/tb_ysyx_22050019_ifu.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_pkg.sv
// Shared definitions for the npc instruction fetch unit: widths, reset PC and fetch FSM states.
package ysyx_22050019_pkg;

    localparam int unsigned IFU_ADDR_W = 32;
    localparam int unsigned IFU_INST_W = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/ysyx_22050019_ifu_pc.sv
// Architectural PC register: redirect target takes priority over the sequential +4 advance.
module ysyx_22050019_ifu_pc
    import ysyx_22050019_pkg::*;
#(
    parameter int unsigned       ADDR_W   = IFU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] advance_base_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = advance_base_i + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22050019_ifu.sv
// Instruction fetch unit: one outstanding memory read, fetched word held until decode takes it.
module ysyx_22050019_ifu
    import ysyx_22050019_pkg::*;
#(
    parameter int unsigned       ADDR_W   = IFU_ADDR_W,
    parameter int unsigned       DATA_W   = IFU_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              rsp_valid_i,
    output logic              rsp_ready_o,
    input  logic [DATA_W-1:0] rsp_data_i,
    input  logic              rsp_err_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_fault_o
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] addr_q, inst_pc_q, pc;
    logic [DATA_W-1:0] inst_q;
    logic              fault_q, kill_q;
    logic              aligned, advance;

    assign aligned = (addr_q[1:0] == 2'b00);
    assign advance = (state_q == StWait) && rsp_valid_i && !kill_q && !redirect_valid_i;

    ysyx_22050019_ifu_pc #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .advance_i       (advance),
        .advance_base_i  (addr_q),
        .pc_o            (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= 1'b0;
            kill_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StReq;
                    addr_q  <= redirect_valid_i ? redirect_pc_i : pc;
                end
                StReq: begin
                    if (!aligned) begin
                        if (redirect_valid_i) begin
                            addr_q <= redirect_pc_i;
                        end else begin
                            state_q   <= StHold;
                            inst_q    <= '0;
                            fault_q   <= 1'b1;
                            inst_pc_q <= addr_q;
                        end
                    end else begin
                        // addr_q must stay frozen while the request is offered
                        if (redirect_valid_i) kill_q <= 1'b1;
                        if (req_ready_i) state_q <= StWait;
                    end
                end
                StWait: begin
                    if (rsp_valid_i) begin
                        if (kill_q || redirect_valid_i) begin
                            kill_q  <= 1'b0;
                            addr_q  <= redirect_valid_i ? redirect_pc_i : pc;
                            state_q <= StReq;
                        end else begin
                            inst_q    <= rsp_err_i ? '0 : rsp_data_i;
                            fault_q   <= rsp_err_i;
                            inst_pc_q <= addr_q;
                            state_q   <= StHold;
                        end
                    end else if (redirect_valid_i) begin
                        kill_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (redirect_valid_i) begin
                        state_q <= StReq;
                        addr_q  <= redirect_pc_i;
                    end else if (inst_ready_i) begin
                        state_q <= StReq;
                        addr_q  <= pc;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_valid_o  = (state_q == StReq) && aligned;
    assign req_addr_o   = addr_q;
    assign rsp_ready_o  = (state_q == StWait);
    // Wrong-path instruction is suppressed in the same cycle the redirect arrives
    assign inst_valid_o = (state_q == StHold) && !redirect_valid_i;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_fault_o = fault_q;

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Self-checking bench for the fetch unit: memory/decode model plus request and instruction scoreboards.
module tb_ysyx_22050019_ifu;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_inst_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [31:0] rsp_data = '0;
    logic        rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    // Stimulus knobs and memory model state
    logic        rst_k = 1'b1, mem_ready_k = 1'b1, dec_ready_k = 1'b1, redir_k = 1'b0;
    logic [31:0] redir_pc_k = '0, err_addr_k = 32'h1;
    int          lat_k = 1;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;

    logic [31:0] exp_req[$];
    exp_inst_t   exp_inst[$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    ysyx_22050019_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .req_valid_o     (req_valid),
        .req_ready_i     (req_ready),
        .req_addr_o      (req_addr),
        .rsp_valid_i     (rsp_valid),
        .rsp_ready_o     (rsp_ready),
        .rsp_data_i      (rsp_data),
        .rsp_err_i       (rsp_err),
        .inst_valid_o    (inst_valid),
        .inst_ready_i    (inst_ready),
        .inst_o          (inst),
        .inst_pc_o       (inst_pc),
        .inst_fault_o    (inst_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a - 32'h7FFF_FFED;
    endfunction

    // One cycle: drive at negedge, then score the handshakes that the next posedge will take.
    task automatic step();
        logic [31:0] ea;
        exp_inst_t   e;
        @(negedge clk);
        rst            = rst_k;
        req_ready      = mem_ready_k;
        inst_ready     = dec_ready_k;
        redirect_valid = redir_k;
        redirect_pc    = redir_pc_k;
        rsp_valid      = mem_busy && (mem_cnt == 0);
        rsp_data       = mem_word(mem_addr);
        rsp_err        = rsp_valid && (mem_addr == err_addr_k);
        #1;
        if (rsp_valid && rsp_ready) mem_busy = 1'b0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
        if (req_valid && req_ready) begin
            n_checks++;
            if (exp_req.size() == 0) begin
                $display("FAIL req_unexpected: addr %h, required no request", req_addr);
            end else begin
                ea = exp_req.pop_front();
                if (req_addr !== ea) $display("FAIL req_addr: got %h required %h", req_addr, ea);
                else n_pass++;
            end
            mem_busy = 1'b1;
            mem_addr = req_addr;
            mem_cnt  = lat_k - 1;
        end
        if (inst_valid && inst_ready) begin
            n_checks++;
            if (exp_inst.size() == 0) begin
                $display("FAIL inst_unexpected: pc %h inst %h, required none", inst_pc, inst);
            end else begin
                e = exp_inst.pop_front();
                if (inst !== e.inst || inst_pc !== e.pc || inst_fault !== e.fault)
                    $display("FAIL inst: got pc %h inst %h fault %b required pc %h inst %h fault %b",
                             inst_pc, inst, inst_fault, e.pc, e.inst, e.fault);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_valid !== 1'b0 || rsp_ready !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL reset_valids: req %b rsp_rdy %b inst %b required 0 0 0",
                     req_valid, rsp_ready, inst_valid);
        else n_pass++;
        n_checks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0)
            $display("FAIL reset_inst: inst %h pc %h fault %b required 0 0 0",
                     inst, inst_pc, inst_fault);
        else n_pass++;
        n_checks++;
        if (req_addr !== 32'h8000_0000) $display("FAIL reset_addr: got %h required 80000000", req_addr);
        else n_pass++;
        rst   = 1'b0;
        rst_k = 1'b0;
        #1;
        n_checks++;
        if (req_valid !== 1'b0) $display("FAIL idle_no_req: req_valid %b required 0", req_valid);
        else n_pass++;
    endtask

    task automatic test_basic();
        exp_req.push_back(32'h8000_0000);
        exp_inst.push_back('{pc: 32'h8000_0000, inst: 32'h0000_0013, fault: 1'b0});
        exp_req.push_back(32'h8000_0004);
        step();
        n_checks++;
        if (req_valid !== 1'b1) $display("FAIL first_req: req_valid %b required 1", req_valid);
        else n_pass++;
        step();
        n_checks++;
        if (rsp_ready !== 1'b1 || inst_valid !== 1'b0)
            $display("FAIL wait_state: rsp_ready %b inst_valid %b required 1 0", rsp_ready, inst_valid);
        else n_pass++;
        step();
        n_checks++;
        if (inst_valid !== 1'b1) $display("FAIL rsp_to_inst: inst_valid %b required 1", inst_valid);
        else n_pass++;
        step();
    endtask

    task automatic test_stall();
        exp_inst.push_back('{pc: 32'h8000_0004, inst: 32'h0000_0017, fault: 1'b0});
        dec_ready_k = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h17 || inst_pc !== 32'h8000_0004)
                $display("FAIL stall_hold: valid %b inst %h pc %h required 1 00000017 80000004",
                         inst_valid, inst, inst_pc);
            else n_pass++;
            n_checks++;
            if (req_valid !== 1'b0) $display("FAIL stall_no_req: req_valid %b required 0", req_valid);
            else n_pass++;
        end
        dec_ready_k = 1'b1;
        mem_ready_k = 1'b0;
        step();
        step();
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0008)
            $display("FAIL stall_next_req: valid %b addr %h required 1 80000008", req_valid, req_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        mem_ready_k = 1'b1;
        lat_k       = 4;
        exp_req.push_back(32'h8000_0008);
        step();
        redir_k    = 1'b1;
        redir_pc_k = 32'h8000_0100;
        for (int i = 0; i < 4; i++) begin
            step();
            redir_k = 1'b0;
            n_checks++;
            if (inst_valid !== 1'b0) $display("FAIL redir_wait_drop: inst_valid %b required 0", inst_valid);
            else n_pass++;
        end
        lat_k = 1;
        exp_req.push_back(32'h8000_0100);
        step();
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0100)
            $display("FAIL redir_target: valid %b addr %h required 1 80000100", req_valid, req_addr);
        else n_pass++;
        mem_ready_k = 1'b0;
    endtask

    task automatic test_misaligned();
        step();
        redir_k    = 1'b1;
        redir_pc_k = 32'h8000_0102;
        step();
        redir_k = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0) $display("FAIL hold_kill: inst_valid %b required 0", inst_valid);
        else n_pass++;
        mem_ready_k = 1'b1;
        exp_inst.push_back('{pc: 32'h8000_0102, inst: 32'h0, fault: 1'b1});
        step();
        n_checks++;
        if (req_valid !== 1'b0) $display("FAIL misaligned_no_req: req_valid %b required 0", req_valid);
        else n_pass++;
        step();
        n_checks++;
        if (inst_valid !== 1'b1 || inst_fault !== 1'b1)
            $display("FAIL misaligned_fault: valid %b fault %b required 1 1", inst_valid, inst_fault);
        else n_pass++;
        redir_k    = 1'b1;
        redir_pc_k = 32'h8000_0008;
        step();
        redir_k = 1'b0;
    endtask

    task automatic test_err_wrap();
        err_addr_k = 32'h8000_0008;
        exp_req.push_back(32'h8000_0008);
        exp_inst.push_back('{pc: 32'h8000_0008, inst: 32'h0, fault: 1'b1});
        exp_req.push_back(32'h8000_000C);
        step();
        n_checks++;
        if (req_valid !== 1'b1) $display("FAIL redir_latency: req_valid %b required 1", req_valid);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (inst_fault !== 1'b1 || inst !== 32'h0)
            $display("FAIL err_fault: fault %b inst %h required 1 00000000", inst_fault, inst);
        else n_pass++;
        step();
        redir_k    = 1'b1;
        redir_pc_k = 32'hFFFF_FFFC;
        exp_req.push_back(32'hFFFF_FFFC);
        step();
        redir_k = 1'b0;
        exp_inst.push_back('{pc: 32'hFFFF_FFFC, inst: 32'h8000_000F, fault: 1'b0});
        exp_req.push_back(32'h0000_0000);
        step();
        step();
        step();
        lat_k = 3;
        step();
        step();
        n_checks++;
        if (rsp_ready !== 1'b1 || inst_valid !== 1'b0)
            $display("FAIL wrap_wait: rsp_ready %b inst_valid %b required 1 0", rsp_ready, inst_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        rst_k = 1'b1;
        step();
        n_checks++;
        if (req_valid !== 1'b0 || rsp_ready !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL midrst_valids: req %b rsp_rdy %b inst %b required 0 0 0",
                     req_valid, rsp_ready, inst_valid);
        else n_pass++;
        n_checks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0 || req_addr !== 32'h8000_0000)
            $display("FAIL midrst_regs: inst %h pc %h fault %b addr %h required 0 0 0 80000000",
                     inst, inst_pc, inst_fault, req_addr);
        else n_pass++;
        step();
        rst_k = 1'b0;
        step();
        n_checks++;
        if (rsp_ready !== 1'b0 || req_valid !== 1'b0)
            $display("FAIL stale_rsp: rsp_ready %b req_valid %b required 0 0", rsp_ready, req_valid);
        else n_pass++;
        mem_busy = 1'b0;
        lat_k    = 1;
        exp_req.push_back(32'h8000_0000);
        exp_inst.push_back('{pc: 32'h8000_0000, inst: 32'h0000_0013, fault: 1'b0});
        step();
        step();
        step();
        mem_ready_k = 1'b0;
        step();
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0004)
            $display("FAIL post_rst_next: valid %b addr %h required 1 80000004", req_valid, req_addr);
        else n_pass++;
        n_checks++;
        if (exp_req.size() != 0 || exp_inst.size() != 0)
            $display("FAIL drain: pending req %0d inst %0d required 0 0", exp_req.size(), exp_inst.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_misaligned();
        test_err_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

endmodule
